// File: rtl/i2sin_if.sv
// rtl/i2sin_if.sv - I2S capture bus: serial ws/sd in, parallel stereo pair out
interface i2sin_if #(
    parameter int N = 24
);
    logic         ws;
    logic         sd;
    logic [N-1:0] l_data;
    logic [N-1:0] r_data;
    logic         data_en;
    logic         locked;

    // master is the serial source and consumer of the parallel pair
    modport master (
        output ws,
        output sd,
        input  l_data,
        input  r_data,
        input  data_en,
        input  locked
    );

    modport slave (
        input  ws,
        input  sd,
        output l_data,
        output r_data,
        output data_en,
        output locked
    );
endinterface

// File: rtl/i2sin.sv
// rtl/i2sin.sv - Philips I2S slave receiver, reassembles MSB-first L/R words into a stereo pair
module i2sin #(
    parameter int BITS_PRECISION = 24
) (
    input  logic    sck,
    input  logic    rst,
    i2sin_if.slave  bus
);
    localparam int N  = BITS_PRECISION;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] N_CNT = CW'(N);

    typedef enum logic [1:0] {
        ARM,
        SYNC,
        RECEIVE
    } state_t;

    state_t         state;
    logic           ws_d;
    logic [N-1:0]   shift_reg;
    logic [CW-1:0]  cnt;
    logic           left_valid;
    logic [N-1:0]   left_hold;
    logic [N-1:0]   l_data_q;
    logic [N-1:0]   r_data_q;
    logic           data_en_q;
    logic           locked_q;

    logic           ws_edge;
    logic           cnt_open;
    logic [N-1:0]   word_next;

    assign ws_edge  = (bus.ws != ws_d);
    assign cnt_open = (cnt < N_CNT);

    // Current sd lands at bit (MSB - cnt); once cnt saturates the word is frozen.
    always_comb begin
        word_next = shift_reg;
        for (int i = 0; i < N; i++) begin
            if (cnt_open && (CW'(N - 1 - i) == cnt)) begin
                word_next[i] = bus.sd;
            end
        end
    end

    always_ff @(posedge sck or negedge rst) begin
        if (!rst) begin
            state      <= ARM;
            ws_d       <= 1'b0;
            shift_reg  <= '0;
            cnt        <= '0;
            left_valid <= 1'b0;
            left_hold  <= '0;
            l_data_q   <= '0;
            r_data_q   <= '0;
            data_en_q  <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            ws_d      <= bus.ws;
            data_en_q <= 1'b0;
            case (state)
                ARM: begin
                    state <= SYNC;
                end
                SYNC: begin
                    // The slot before the first edge is of unknown length, so it is discarded.
                    if (ws_edge) begin
                        shift_reg <= '0;
                        cnt       <= '0;
                        locked_q  <= 1'b1;
                        state     <= RECEIVE;
                    end
                end
                RECEIVE: begin
                    if (ws_edge) begin
                        // ws_d names the channel whose slot just ended.
                        if (!ws_d) begin
                            left_hold  <= word_next;
                            left_valid <= 1'b1;
                        end else if (left_valid) begin
                            l_data_q   <= left_hold;
                            r_data_q   <= word_next;
                            data_en_q  <= 1'b1;
                            left_valid <= 1'b0;
                        end
                        shift_reg <= '0;
                        cnt       <= '0;
                    end else if (cnt_open) begin
                        shift_reg <= word_next;
                        cnt       <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ARM;
                end
            endcase
        end
    end

    assign bus.l_data  = l_data_q;
    assign bus.r_data  = r_data_q;
    assign bus.data_en = data_en_q;
    assign bus.locked  = locked_q;
endmodule

// File: tb/tb_i2sin.sv
// tb/tb_i2sin.sv - scoreboard bench for i2sin: directed I2S frames, monitor checks each strobe
module tb_i2sin;
    logic sck;
    logic rst;

    i2sin_if #(.N(24)) bus ();

    i2sin #(.BITS_PRECISION(24)) dut (
        .sck (sck),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        int          gap;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    logic prev_bit = 1'b0;

    initial sck = 1'b0;
    always #5 sck = ~sck;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] justify(input logic [31:0] v, input int s);
        logic [31:0] t;
        if (s >= 24) t = v >> (s - 24);
        else         t = v << (24 - s);
        return t[23:0];
    endfunction

    // b is the bit aligned with ws in slot terms; sd carries it one sck later (Philips delay).
    task automatic drive_cycle(input logic w, input logic b);
        @(negedge sck);
        bus.ws   = w;
        bus.sd   = prev_bit;
        prev_bit = b;
    endtask

    task automatic send_slot(input logic w, input logic [31:0] val, input int s);
        for (int i = 0; i < s; i++) drive_cycle(w, val[s-1-i]);
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int s,
                              input bit expect_it, input bit first);
        exp_t e;
        send_slot(1'b0, l, s);
        send_slot(1'b1, r, s);
        if (expect_it) begin
            e.l   = justify(l, s);
            e.r   = justify(r, s);
            e.gap = first ? 0 : 2 * s;
            sb.push_back(e);
        end
    endtask

    task automatic flush_and_drain(input string name);
        drive_cycle(1'b0, 1'b0);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge sck);
        @(negedge sck);
        check(name, sb.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_l_data"},  bus.l_data,  0);
        check({tag, "_r_data"},  bus.r_data,  0);
        check({tag, "_data_en"}, bus.data_en, 0);
        check({tag, "_locked"},  bus.locked,  0);
    endtask

    always @(posedge sck) begin
        exp_t e;
        #1;
        cyc++;
        if (bus.data_en === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_strobe: l=%h r=%h with empty scoreboard (t=%0t)",
                         bus.l_data, bus.r_data, $time);
            end else begin
                e = sb.pop_front();
                check("l_data", bus.l_data, e.l);
                check("r_data", bus.r_data, e.r);
                check("locked_at_strobe", bus.locked, 1);
                if (e.gap != 0) check("strobe_period", cyc - last_cyc, e.gap);
            end
            last_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b0;
        bus.ws = 1'b0;
        bus.sd = 1'b0;
        #23;
        check_reset_outputs("por");
        @(negedge sck);
        rst = 1'b1;

        // First right slot has no preceding left: locks but drops that word.
        send_frame(32'h0, 32'h00FFFFFF, 24, 1'b0, 1'b0);
        check("locked_after_sync", bus.locked, 1);
        check("no_strobe_yet", bus.data_en, 0);

        send_frame(32'h000001, 32'h000002, 24, 1'b1, 1'b1);
        send_frame(32'h000001, 32'h000002, 24, 1'b1, 1'b0);
        send_frame(32'h000001, 32'h000002, 24, 1'b1, 1'b0);
        send_frame(32'h800000, 32'h800000, 24, 1'b1, 1'b0);
        send_frame(32'h800000, 32'h800000, 24, 1'b1, 1'b0);
        send_frame(32'hA5A5A5FF, 32'h5A5A5AFF, 32, 1'b1, 1'b0);
        send_frame(32'hA5A5A5FF, 32'h5A5A5AFF, 32, 1'b1, 1'b0);
        send_frame(32'h1234, 32'hABCD, 16, 1'b1, 1'b0);
        send_frame(32'h1234, 32'hABCD, 16, 1'b1, 1'b0);
        send_frame(32'h1, 32'h0, 1, 1'b1, 1'b0);
        send_frame(32'h0, 32'h1, 1, 1'b1, 1'b0);
        send_frame(32'hC35A0F, 32'h0FF0A5, 24, 1'b1, 1'b0);
        flush_and_drain("drain_main");

        // Reset mid-left word: outputs clear asynchronously, partial data is lost.
        send_slot(1'b0, 32'hFF, 8);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_mid_left");
        @(negedge sck);
        @(negedge sck);
        rst = 1'b1;
        send_slot(1'b0, 32'hFFFF, 14);
        check("locked_before_edge", bus.locked, 0);
        send_slot(1'b1, 32'hFFFFFF, 24);
        send_frame(32'h3C3C3C, 32'hC3C3C3, 24, 1'b1, 1'b1);
        send_frame(32'h010203, 32'h040506, 24, 1'b1, 1'b0);
        flush_and_drain("drain_after_left_reset");

        // Reset released with ws high, mid right word.
        send_slot(1'b1, 32'h3FF, 10);
        @(negedge sck);
        rst = 1'b0;
        @(negedge sck);
        rst = 1'b1;
        send_slot(1'b1, 32'h3FF, 10);
        check("locked_in_partial_right", bus.locked, 0);
        send_frame(32'h7E7E7E, 32'h818181, 24, 1'b1, 1'b1);
        send_frame(32'h000000, 32'hFFFFFF, 24, 1'b1, 1'b0);
        flush_and_drain("drain_after_right_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
